// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction,
// drives datapath enables/selects, flags illegal opcodes and counts retirements.
module multicycle_control #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state;
  state_t state_next;
  logic   ready;
  logic   retire;
  logic   set_illegal;

  // The branch decision uses zero inside the datapath, not here.
  logic unused_ok;
  assign unused_ok = zero ^ mem_ready;

  assign ready   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      if (set_illegal) illegal_op <= 1'b1;
      if (retire)      retired    <= retired + CNT_W'(1);
    end
  end

  // Next state and control outputs, decoded from the registered state.
  always_comb begin
    state_next    = S_RST;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state)
      S_RST: state_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = ready;
        ir_write  = ready;
        state_next = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default: begin
            state_next  = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        retire     = ready;
        state_next = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected cycle traces
// built from the instruction rules, compared every cycle.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state_o;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CNT_W-1:0] m_retired;
  logic             m_illegal;

  multicycle_control #(.CNT_W(CNT_W), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 clk = ~clk;

  wire [15:0] ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Control word required in each state (FETCH strobes added separately when ready).
  function automatic logic [15:0] ctl_for(input int st);
    case (st)
      1:  return 16'h1010;
      2:  return 16'h0030;
      3:  return 16'h0060;
      4:  return 16'h3000;
      5:  return 16'h0280;
      6:  return 16'h2800;
      7:  return 16'h0048;
      8:  return 16'h0180;
      9:  return 16'h4045;
      10: return 16'h8002;
      11: return 16'h0060;
      12: return 16'h0080;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp_v);
    end
  endtask

  task automatic check_all(input int st, input logic rdy);
    logic [15:0] e;
    e = ctl_for(st);
    if (st == 1 && rdy) e = e | 16'h8400;
    check("state", 32'(state_o), 32'(st));
    check("ctl", 32'(ctl), 32'(e));
    check("retired", 32'(retired), 32'(m_retired));
    check("illegal", 32'(illegal_op), 32'(m_illegal));
  endtask

  // One clock: drive mem_ready at the negedge, check, then advance to the next negedge.
  task automatic step(input int st, input logic rdy);
    mem_ready = rdy;
    #1;
    check_all(st, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // cls: 0 lw, 1 sw, 2 R-type, 3 beq, 4 j, 5 addi, 6 illegal
  task automatic run_instr(input int cls, input logic zv, input int fw, input int mw);
    logic [5:0] op;
    case (cls)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b000010;
      5: op = 6'b001000;
      default: begin
        op = 6'($urandom);
        if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000})
          op = 6'h3F;
      end
    endcase
    opcode = op;
    zero   = zv;
    for (int i = 0; i < fw; i++) step(1, 1'b0);
    step(1, 1'b1);
    step(2, rbit());
    case (cls)
      0: begin
        step(3, rbit());
        for (int i = 0; i < mw; i++) step(4, 1'b0);
        step(4, 1'b1);
        step(5, rbit());
      end
      1: begin
        step(3, rbit());
        for (int i = 0; i < mw; i++) step(6, 1'b0);
        step(6, 1'b1);
      end
      2: begin step(7, rbit()); step(8, rbit()); end
      3: step(9, rbit());
      4: step(10, rbit());
      5: begin step(11, rbit()); step(12, rbit()); end
      default: ;
    endcase
    if (cls == 6) m_illegal = 1'b1;
    else          m_retired = m_retired + CNT_W'(1);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    m_retired = '0;
    m_illegal = 1'b0;
    #1;
    check_all(0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(0, 1'b1);

    // Directed: lw, sw with 3 waits, beq taken/not taken, fetch wait, illegal then R-type.
    run_instr(0, 1'b0, 0, 0);
    run_instr(1, 1'b0, 0, 3);
    run_instr(3, 1'b1, 0, 0);
    run_instr(3, 1'b0, 0, 0);
    run_instr(2, 1'b0, 2, 0);
    run_instr(6, 1'b0, 0, 0);
    run_instr(2, 1'b0, 0, 0);
    run_instr(4, 1'b0, 1, 0);
    run_instr(5, 1'b0, 0, 0);

    // Async reset while in EXEC.
    opcode = 6'b000000;
    step(1, 1'b1);
    step(2, 1'b1);
    mem_ready = 1'b1;
    #1;
    check_all(7, 1'b1);
    #1 reset = 1'b1;
    #1;
    m_retired = '0;
    m_illegal = 1'b0;
    check_all(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1'b1);

    // Random instruction mix with random wait states; counter wraps several times.
    for (int k = 0; k < 80; k++)
      run_instr(int'($urandom_range(0, 6)), rbit(), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    step(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi. Drives every datapath enable and mux select, including the 2-bit alu_op consumed by the ALU control decoder. Handles variable-latency memory with a ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat memory as single-cycle (mem_ready ignored, read as 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero=1
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  1 = MDR to register file
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
state_o  out  4  current state encoding (debug)
illegal_op  out  1  sticky: undefined opcode decoded
retired  out  CNT_W  instructions completed, wraps

Behaviour:
- States/encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12. Other codes are unreachable and map to RST on the next edge.
- Reset (async assert): state=RST, illegal_op=0, retired=0. In RST every control output is 0. The first edge after reset deasserts moves the FSM to FETCH.
- Defaults: all strobes/enables 0; alu_src_b/alu_op/pc_source 00 unless set below.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. While mem_ready=0, hold FETCH with pc_write=ir_write=0. When mem_ready=1, assert pc_write=1 and ir_write=1 that cycle, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → EXEC
  - beq 000100 → BRANCH
  - j 000010 → JUMP
  - addi 001000 → ADDIEX
  - any other → FETCH, set illegal_op=1 (sticky), retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- Retirement: retired increments by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, JUMP or ADDIWB. It wraps from all-ones to 0.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait states: each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle. Strobes stay asserted throughout.
- Reset asserted mid-instruction: immediate return to RST. No partial reg_write/mem_write after the reset edge.
- Control outputs are combinational from the registered state, plus mem_ready for the FETCH gating.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 always → states 1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in the state-5 cycle. retired=1.
- sw with mem_ready low 3 cycles in MEMWR → mem_write high 4 consecutive cycles, i_or_d=1. Return to FETCH. retired increments once.
- beq, zero=1, then beq, zero=0 → BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01 in both. Each takes 3 cycles. retired=2.
- FETCH with mem_ready=0 for 2 cycles → mem_read=1 for 3 cycles. pc_write and ir_write pulse only in the third cycle.
- Opcode 111111 → DECODE→FETCH, illegal_op=1 and stays 1 through a following R-type. retired unchanged by the illegal op.
- Async reset asserted in EXEC between clock edges → state_o=0 and all outputs 0 immediately. retired=0 and illegal_op=0. FETCH on the first edge after release.
